// File: rtl/cpc_bus_pkg.sv
// Shared types and constants for the CPC expansion-RAM bank controller.
// Holds the FSM state enums, the RAM-config port tag and the page map.
package cpc_bus_pkg;

  typedef enum logic {P_IDLE, P_HOLD}   port_state_t;
  typedef enum logic {M_IDLE, M_ACTIVE} mem_state_t;

  // Physical 16K page: 0-3 internal, 4-7 expansion (bit 2 is the expansion flag).
  typedef logic [2:0] page_t;

  localparam logic [1:0] RAMCFG_TAG = 2'b11;

  // Indexed [cfg][slot], where slot = A[15:14].
  localparam page_t PAGE_MAP [8][4] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd0, 3'd1, 3'd2, 3'd7},
    '{3'd4, 3'd5, 3'd6, 3'd7},
    '{3'd0, 3'd3, 3'd2, 3'd7},
    '{3'd0, 3'd4, 3'd2, 3'd3},
    '{3'd0, 3'd5, 3'd2, 3'd3},
    '{3'd0, 3'd6, 3'd2, 3'd3},
    '{3'd0, 3'd7, 3'd2, 3'd3}
  };

endpackage

// File: rtl/cpc_ram_bank_ctrl_if.sv
// Z80 side of the 50-way expansion bus plus the expansion SRAM control lines.
// master = backplane/CPU side, slave = this card.
interface cpc_ram_bank_ctrl_if #(parameter int NBANK_BITS = 3);
  logic [15:0]           A;
  logic [7:0]            D;
  logic                  MREQ_B;
  logic                  IOREQ_B;
  logic                  RD_B;
  logic                  WR_B;
  logic                  RFSH_B;
  logic                  RAMDIS;
  logic [NBANK_BITS+1:0] EXP_A;
  logic                  EXP_CE_B;
  logic                  EXP_OE_B;
  logic                  EXP_WE_B;

  modport master (
    output A, D, MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B,
    input  RAMDIS, EXP_A, EXP_CE_B, EXP_OE_B, EXP_WE_B
  );

  modport slave (
    input  A, D, MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B,
    output RAMDIS, EXP_A, EXP_CE_B, EXP_OE_B, EXP_WE_B
  );
endinterface

// File: rtl/cpc_page_map.sv
// Combinational (cfg, slot) -> physical page lookup, split into the
// expansion flag and the low two page bits.
module cpc_page_map
  import cpc_bus_pkg::*;
(
  input  logic [2:0] cfg,
  input  logic [1:0] slot,
  output logic       exp,
  output logic [1:0] page
);

  page_t phys;

  assign phys = PAGE_MAP[cfg][slot];
  assign exp  = phys[2];
  assign page = phys[1:0];

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// Card-side responder: snoops Gate Array RAM-config writes and, per memory
// cycle, disables internal RAM and drives the expansion SRAM when mapped.
module cpc_ram_bank_ctrl
  import cpc_bus_pkg::*;
#(
  parameter int NBANK_BITS = 3,
  parameter bit CHECK_A14  = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET_B,
  cpc_ram_bank_ctrl_if.slave  bus
);

  // Only the slot bits of A ever feed a decision, so only those are sampled.
  logic [1:0] a_s;
  logic [7:0] d_s;
  logic       mreq_s, ioreq_s, rd_s, wr_s, rfsh_s;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      a_s     <= '0;
      d_s     <= '0;
      mreq_s  <= 1'b1;
      ioreq_s <= 1'b1;
      rd_s    <= 1'b1;
      wr_s    <= 1'b1;
      rfsh_s  <= 1'b1;
    end else begin
      a_s     <= bus.A[15:14];
      d_s     <= bus.D;
      mreq_s  <= bus.MREQ_B;
      ioreq_s <= bus.IOREQ_B;
      rd_s    <= bus.RD_B;
      wr_s    <= bus.WR_B;
      rfsh_s  <= bus.RFSH_B;
    end
  end

  logic a14_ok, port_hit, mem_start;

  assign a14_ok    = CHECK_A14 ? a_s[0] : 1'b1;
  assign port_hit  = !ioreq_s && !wr_s && !a_s[1] && a14_ok && (d_s[7:6] == RAMCFG_TAG);
  assign mem_start = !mreq_s && rfsh_s && (!rd_s || !wr_s);

  port_state_t           port_state;
  logic [2:0]            cfg_reg;
  logic [NBANK_BITS-1:0] bank_reg;

  // P_HOLD blocks re-latching until the I/O write ends, so wait states
  // stretch the cycle without producing extra latches.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      port_state <= P_IDLE;
      cfg_reg    <= '0;
      bank_reg   <= '0;
    end else begin
      case (port_state)
        P_IDLE: begin
          if (port_hit) begin
            port_state <= P_HOLD;
            cfg_reg    <= d_s[2:0];
            bank_reg   <= d_s[NBANK_BITS+2:3];
          end
        end
        P_HOLD: begin
          if (ioreq_s || wr_s) port_state <= P_IDLE;
        end
        default: port_state <= P_IDLE;
      endcase
    end
  end

  logic       map_exp;
  logic [1:0] map_page;

  cpc_page_map u_page_map (
    .cfg  (cfg_reg),
    .slot (a_s),
    .exp  (map_exp),
    .page (map_page)
  );

  mem_state_t            mem_state;
  logic                  act_exp_reg;
  logic                  ramdis_reg, ce_b_reg, oe_b_reg, we_b_reg;
  logic [NBANK_BITS+1:0] exp_a_reg;

  // The page is frozen on entry; cfg/bank reads here see the pre-latch
  // values if a port latch lands on the same edge.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      mem_state   <= M_IDLE;
      act_exp_reg <= 1'b0;
      ramdis_reg  <= 1'b0;
      ce_b_reg    <= 1'b1;
      oe_b_reg    <= 1'b1;
      we_b_reg    <= 1'b1;
      exp_a_reg   <= '0;
    end else begin
      case (mem_state)
        M_IDLE: begin
          if (mem_start) begin
            mem_state   <= M_ACTIVE;
            act_exp_reg <= map_exp;
            if (map_exp) begin
              ramdis_reg <= 1'b1;
              ce_b_reg   <= 1'b0;
              oe_b_reg   <= rd_s;
              we_b_reg   <= wr_s;
              exp_a_reg  <= {bank_reg, map_page};
            end
          end
        end
        M_ACTIVE: begin
          if (mreq_s) begin
            mem_state   <= M_IDLE;
            act_exp_reg <= 1'b0;
            ramdis_reg  <= 1'b0;
            ce_b_reg    <= 1'b1;
            oe_b_reg    <= 1'b1;
            we_b_reg    <= 1'b1;
          end else if (act_exp_reg) begin
            we_b_reg <= wr_s;
          end
        end
        default: mem_state <= M_IDLE;
      endcase
    end
  end

  assign bus.RAMDIS   = ramdis_reg;
  assign bus.EXP_CE_B = ce_b_reg;
  assign bus.EXP_OE_B = oe_b_reg;
  assign bus.EXP_WE_B = we_b_reg;
  assign bus.EXP_A    = exp_a_reg;

endmodule
